// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG word packer.
// The ordering constants give the legal values of the packer's LSB_FIRST parameter.
package trng_pkg;

   localparam int WORD_W_DEF     = 64;
   localparam int FIFO_DEPTH_DEF = 4;

   localparam int MSB_FIRST = 0;
   localparam int LSB_FIRST = 1;

   // Pointer width for a power-of-two FIFO; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/trng_word_packer_if.sv
// Completed-word stream from the packer to the readout logic (valid/ready).
interface trng_word_packer_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/trng_word_fifo.sv
// First-word-fall-through FIFO for completed words.
// A push at full is accepted only when a pop happens in the same cycle.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [ptr_w(DEPTH):0]      count
);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gate the head so an empty FIFO presents zero instead of stale data.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/trng_word_packer.sv
// Packs qualified entropy bits into words, buffers them in a FWFT FIFO and
// tracks words lost to a full FIFO with a sticky flag and saturating counter.
module trng_word_packer #(
    parameter int WORD_W     = trng_pkg::WORD_W_DEF,
    parameter int FIFO_DEPTH = trng_pkg::FIFO_DEPTH_DEF,
    parameter int LSB_FIRST  = trng_pkg::MSB_FIRST,
    parameter int DROP_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          flush,
    trng_word_packer_if.master            stream,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);
    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] head;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;

    generate
        if (LSB_FIRST == trng_pkg::LSB_FIRST) begin : g_lsb_first
            assign asm_next = {bit_in, asm_q[WORD_W-1:1]};
        end else begin : g_msb_first
            assign asm_next = {asm_q[WORD_W-2:0], bit_in};
        end
    endgenerate

    // flush outranks bit_valid, so a completing bit under flush never pushes.
    assign accept = bit_valid & ~flush;
    assign push   = accept & (bit_cnt == CNT_LAST);
    assign pop    = ~empty & stream.word_ready;
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q   <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                asm_q   <= asm_next;
                bit_cnt <= push ? '0 : bit_cnt + CNT_W'(1);
            end else if (flush) begin
                bit_cnt <= '0;
            end
        end
    end

    // A drop in the same cycle as ovf_clr restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    trng_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (asm_next),
        .pop       (pop),
        .rd_data   (head),
        .full      (full),
        .empty     (empty),
        .count     (fill_level)
    );

    assign stream.word_data  = head;
    assign stream.word_valid = ~empty;
endmodule

// File: tb/tb_trng_word_packer.sv
// Directed bench: an MSB-first packer and an LSB-first packer (2-bit drop counter)
// driven by the same bit stream, checked against hand-computed words.
module tb_trng_word_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        flush;
    logic        word_ready;
    logic        ovf_clr;
    logic [2:0]  fill_m, fill_l;
    logic        ovf_m, ovf_l;
    logic [15:0] drop_m;
    logic [1:0]  drop_l;
    int          checks = 0;
    int          errors = 0;
    logic        seen_valid;

    trng_word_packer_if #(.WORD_W(8)) if_m ();
    trng_word_packer_if #(.WORD_W(8)) if_l ();
    assign if_m.word_ready = word_ready;
    assign if_l.word_ready = word_ready;

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .LSB_FIRST(0), .DROP_CNT_W(16)) u_msb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
        .stream(if_m), .fill_level(fill_m), .overflow(ovf_m), .ovf_clr(ovf_clr), .drop_cnt(drop_m));

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1), .DROP_CNT_W(2)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
        .stream(if_l), .fill_level(fill_l), .overflow(ovf_l), .ovf_clr(ovf_clr), .drop_cnt(drop_l));

    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] v;
        v = w;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_head(input string tag, input logic [7:0] w);
        check({tag, "_valid_m"}, if_m.word_valid, 1'b1);
        check({tag, "_data_m"},  if_m.word_data,  w);
        check({tag, "_data_l"},  if_l.word_data,  rev8(w));
    endtask

    logic [7:0] ovf_words [4];
    logic [7:0] full_words [4];

    initial begin
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0;
        word_ready = 1'b1; ovf_clr = 1'b0;
        ovf_words  = '{8'h11, 8'h22, 8'h33, 8'h44};
        full_words = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_valid", if_m.word_valid, 1'b0);
        check("rst_fill",  fill_m, 3'd0);
        check("rst_ovf",   ovf_m, 1'b0);
        check("rst_drop",  drop_m, 16'd0);
        check("rst_data",  if_m.word_data, 8'h00);
        check("rst_data_l", if_l.word_data, 8'h00);

        // 1,0,1,0,0,1,0,1 -> A5 in both orders
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(0);
        check("a5_early_valid", if_m.word_valid, 1'b0);
        send_bit(1);
        check_head("a5", 8'hA5);
        check("a5_fill", fill_m, 3'd1);
        tick();
        check("a5_one_cycle", if_m.word_valid, 1'b0);

        // 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
        send_word(8'hC0);
        check("asym_m", if_m.word_data, 8'hC0);
        check("asym_l", if_l.word_data, 8'h03);
        tick();

        // Backpressure: 6 words into a 4-deep FIFO, then 2 more to saturate the 2-bit counter
        word_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_word(8'h11 * (i + 1));
        check("ovf_fill", fill_m, 3'd4);
        check("ovf_flag_m", ovf_m, 1'b1);
        check("ovf_flag_l", ovf_l, 1'b1);
        check("ovf_drop_m", drop_m, 16'd2);
        check("ovf_drop_l", drop_l, 2'd2);
        check("ovf_hold", if_m.word_data, 8'h11);
        send_word(8'h77);
        send_word(8'h88);
        check("sat_drop_m", drop_m, 16'd4);
        check("sat_drop_l", drop_l, 2'd3);
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("ovf_pop", ovf_words[i]);
            tick();
        end
        check("ovf_drained", if_m.word_valid, 1'b0);
        check("ovf_kept", ovf_m, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf", ovf_m, 1'b0);
        check("clr_drop_m", drop_m, 16'd0);
        check("clr_drop_l", drop_l, 2'd0);

        // Flush with a 6th bit in the same cycle, then 3C
        for (int i = 0; i < 5; i++) send_bit(1);
        bit_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
        tick();
        bit_valid = 1'b0; flush = 1'b0;
        seen_valid = 1'b0;
        send_bit(0); seen_valid |= if_m.word_valid;
        send_bit(0); seen_valid |= if_m.word_valid;
        send_bit(1); seen_valid |= if_m.word_valid;
        send_bit(1); seen_valid |= if_m.word_valid;
        send_bit(1); seen_valid |= if_m.word_valid;
        send_bit(1); seen_valid |= if_m.word_valid;
        send_bit(0); seen_valid |= if_m.word_valid;
        check("flush_no_early_word", seen_valid, 1'b0);
        send_bit(0);
        check_head("flush_3c", 8'h3C);
        tick();
        check("flush_single", if_m.word_valid, 1'b0);

        // Flush on the completing bit: no push, next 8 bits form a new word
        for (int i = 0; i < 7; i++) send_bit(1);
        bit_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
        tick();
        bit_valid = 1'b0; flush = 1'b0;
        check("flush_last_valid", if_m.word_valid, 1'b0);
        check("flush_last_fill", fill_m, 3'd0);
        send_word(8'h5A);
        check_head("after_flush_5a", 8'h5A);
        tick();

        // Push and pop together at full
        word_ready = 1'b0;
        send_word(8'hA1); send_word(8'hA2); send_word(8'hA3); send_word(8'hA4);
        check("full_fill", fill_m, 3'd4);
        for (int i = 7; i >= 1; i--) send_bit(i[2:0] inside {3'd7, 3'd5, 3'd4, 3'd2});
        check_head("full_head", 8'hA1);
        word_ready = 1'b1;
        send_bit(1);
        check("pp_fill", fill_m, 3'd4);
        check("pp_ovf", ovf_m, 1'b0);
        check("pp_drop", drop_m, 16'd0);
        for (int i = 0; i < 4; i++) begin
            check_head("pp_order", full_words[i]);
            tick();
        end
        check("pp_drained", fill_m, 3'd0);

        // Asynchronous reset between edges with 2 words buffered and 3 bits pending
        word_ready = 1'b0;
        send_word(8'h12); send_word(8'h34);
        send_bit(1); send_bit(0); send_bit(1);
        check("pre_rst_fill", fill_m, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", if_m.word_valid, 1'b0);
        check("arst_fill", fill_m, 3'd0);
        check("arst_data", if_m.word_data, 8'h00);
        tick();
        rst_n = 1'b1;
        word_ready = 1'b1;
        send_word(8'hE7);
        check_head("post_rst", 8'hE7);
        check("post_rst_fill", fill_m, 3'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
- Parametrised successor to the TRNG bit-to-word collector.
- Packs a stream of qualified entropy bits into WORD_W-bit words and selects MSB-first or LSB-first bit ordering.
- Buffers completed words in a small FIFO behind a valid/ready output handshake, and reports FIFO overflow and lost words.
- Sits between the ring-oscillator bit source / post-processor and the AXI/DMA readout logic.

Parameters:
- WORD_W, 64, output word width in bits; legal range 8..128.
- FIFO_DEPTH, 4, number of completed words buffered; power of two, minimum 2.
- LSB_FIRST, 0, bit ordering. 0: the first accepted bit lands in word[WORD_W-1] (shift-left). 1: the first accepted bit lands in word[0].
- DROP_CNT_W, 16, width of the saturating lost-word counter.

Ports:
- clk, input, 1, single system clock; all logic is on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- bit_in, input, 1, entropy bit; sampled only when bit_valid=1.
- bit_valid, input, 1, qualifies bit_in for one cycle.
- flush, input, 1, synchronous; discards the partial word being assembled.
- word_data, output, WORD_W, head-of-FIFO word (first-word-fall-through).
- word_valid, output, 1, FIFO not empty.
- word_ready, input, 1, consumer accepts word_data when word_valid=1 and word_ready=1.
- fill_level, output, $clog2(FIFO_DEPTH)+1, number of words currently held.
- overflow, output, 1, sticky flag: at least one completed word was dropped.
- ovf_clr, input, 1, synchronous clear of overflow and drop_cnt.
- drop_cnt, output, DROP_CNT_W, saturating count of dropped words.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Partial word, bit counter and FIFO pointers are cleared.
  - word_data=0, word_valid=0, fill_level=0, overflow=0, drop_cnt=0.
  - Reset mid-word discards the partial word. Reset with a non-empty FIFO discards all buffered words.
- Assembly:
  - Each cycle with bit_valid=1 shifts bit_in into the assembly register and increments the bit counter (range 0..WORD_W-1).
  - On the cycle the counter equals WORD_W-1 with bit_valid=1:
    - the completed word, including that bit, is pushed to the FIFO;
    - the counter wraps to 0;
    - the assembly register is not cleared, because it is overwritten by subsequent bits.
- Latency: a word whose last bit is accepted in cycle N appears on word_data/word_valid in cycle N+1, provided the FIFO was empty.
- Output handshake:
  - A pop occurs on word_valid & word_ready.
  - word_data must hold stable while word_valid=1 and word_ready=0.
  - word_ready while empty has no effect.
- Full FIFO:
  - If a push occurs while fill_level==FIFO_DEPTH and there is no pop in the same cycle, the new word is dropped, overflow is set and drop_cnt increments.
  - drop_cnt saturates at all-ones.
  - Buffered words are never overwritten.
- Simultaneous push and pop:
  - Always legal, including at full and with FIFO_DEPTH=2.
  - fill_level is unchanged and no drop occurs.
  - Push to an empty FIFO with no pop: word_valid rises the next cycle.
- flush:
  - Clears the bit counter; the partial word is lost.
  - FIFO contents are unaffected.
  - flush together with bit_valid: flush wins and that bit is discarded, so the next accepted bit starts a new word.
  - flush in the same cycle as a completing bit: the completing bit is discarded and no push occurs.
- ovf_clr:
  - Clears overflow and drop_cnt.
  - ovf_clr in the same cycle as a drop: the drop wins, giving overflow=1 and drop_cnt=1.
- fill_level: the registered occupancy after the current cycle's push/pop.

Decomposition:
- Package trng_pkg:
  - default WORD_W and FIFO_DEPTH constants;
  - ordering constants MSB_FIRST=0 / LSB_FIRST=1;
  - a function computing the pointer width from FIFO_DEPTH.
- Sub-module trng_word_fifo: synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH.
  - Signals: push, pop, full, empty, count.
  - It is instantiated once. Drop logic, counters and the assembly register stay in the top.

Test Plan (WORD_W=8 and FIFO_DEPTH=4 unless stated):
- Reset: after reset release, word_valid=0, fill_level=0, overflow=0, drop_cnt=0, word_data=8'h00.
- MSB-first, LSB_FIRST=0:
  - Stimulus: bits 1,0,1,0,0,1,0,1 on consecutive cycles with word_ready=1.
  - Response: word_data=8'hA5 with word_valid=1 exactly one cycle after the 8th bit, for one cycle.
- LSB-first, LSB_FIRST=1: the same bit sequence gives word_data=8'hA5 bit-reversed, i.e. 8'hA5.
- LSB-first asymmetric sequence: bits 1,1,0,0,0,0,0,0 give 8'h03 (MSB-first gives 8'hC0).
- Backpressure and overflow:
  - Stimulus: word_ready=0 while 6 words are completed.
  - Response: fill_level=4, overflow=1, drop_cnt=2; then word_ready=1 pops the first 4 words in order.
  - Follow-up: ovf_clr pulse gives overflow=0, drop_cnt=0.
- Flush: feed 5 bits, flush with a 6th bit_valid in the same cycle, then 8 bits 8'h3C MSB-first. Exactly one word, 8'h3C, is output.
- Full push+pop:
  - Stimulus: fill_level=4 and word_ready=1 in the same cycle as a completing bit.
  - Response: fill_level stays 4, overflow stays 0, and the output order is preserved.
- Asynchronous reset mid-word:
  - Stimulus: assert rst_n=0 between clock edges after 3 bits with 2 words buffered.
  - Response: outputs are at reset values immediately; after release, 8 bits yield one correct word.
